regfile_block_mover: RTL and testbench
======================================

// Module: regfile_block_mover
// PURPOSE
//  Initiator for the 64x16 register file: copies or fills a block of registers without CPU involvement.
//  Drives port B to read the source and port A to write the destination, one register per cycle.
//  Sits between game-state control logic and the register file.
//  Used for sprite/score table moves and frame-state clears.
// PARAMETERS
//  AW  6   register address width (64 registers, addresses wrap mod 2**AW)
//  DW  16  register data width
// PORTS
//  Clock      in   1     single clock, all state updates on posedge
//  nReset     in   1     asynchronous, active-low reset
//  Start      in   1     1-cycle request; sampled only in IDLE
//  Fill       in   1     0 = copy Src->Dst, 1 = write FillData to Dst
//  SrcBase    in   AW    first source register (copy only)
//  DstBase    in   AW    first destination register
//  Count      in   AW+1  registers to move, 0..64
//  FillData   in   DW    fill value
//  ReadDataB  in   DW    register file port B read data (asynchronous)
//  AddressA   out  AW    register file write address
//  AddressB   out  AW    register file read address
//  WriteData  out  DW    register file write data
//  WriteEnable out 1     register file write strobe
//  Busy       out  1     transfer in progress
//  Done       out  1     1-cycle completion pulse
//  Error      out  1     1-cycle pulse: Start rejected, Count > 64
// BEHAVIOUR
//  Reset (async, any time): state IDLE; WriteEnable=0, Busy=0, Done=0, Error=0.
//   AddressA, AddressB and the internal counters reset to 0.
//   A write in progress is abandoned. Rows already written stay written; no resume.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE, Start=1:
//   Count > 64 -> Error=1 next cycle, stay IDLE.
//   Count == 0 -> DONE next cycle. No writes.
//   Otherwise  -> latch Fill, FillData, bases and Count, then go to RUN.
//  IDLE, Start=0: no change.
//  Start while not IDLE: ignored. Operands are not re-sampled.
//  Direction (copy only), evaluated at Start:
//   D = (DstBase - SrcBase) mod 64.
//   If 1 <= D <= Count-1, the blocks overlap forward: go descending.
//    First pair is (SrcBase+Count-1, DstBase+Count-1); pointers decrement.
//   Otherwise go ascending from (SrcBase, DstBase); pointers increment.
//   Fill always ascends.
//  Pointer arithmetic is mod 64: blocks may wrap past 63 to 0.
//  RUN: one register per cycle, Count cycles exactly.
//   WriteEnable=1; AddressA = dst pointer; AddressB = src pointer.
//   WriteData = Fill ? FillData_latched : ReadDataB (combinational path).
//   Write lands at the posedge ending the cycle.
//   Last pair written -> DONE.
//  DONE: Done=1 for one cycle, WriteEnable=0, then IDLE.
//  Busy = (state != IDLE); it is high during the DONE cycle.
//  Latency: Start accepted at edge k.
//   Writes occur on edges k+1..k+Count.
//   Done is high in cycle k+Count+1.
//   Next Start is accepted at edge k+Count+2.
//  WriteEnable is never high outside RUN, and is never high in the cycle after reset release.
// TESTING
//  1. Copy Src=4, Dst=20, Count=3, regs 4..6 = A1,A2,A3
//     -> regs 20..22 = A1,A2,A3; WriteEnable high exactly 3 cycles; Done in cycle 5 after Start.
//  2. Forward overlap Src=10, Dst=12, Count=4, regs 10..13 = 1,2,3,4
//     -> AddressA sequence 15,14,13,12; regs 12..15 = 1,2,3,4.
//  3. Wrap: Fill=1, Dst=62, Count=4, FillData=16'hBEEF
//     -> regs 62,63,0,1 = BEEF; reg 2 unchanged.
//  4. Count=0 -> no write, Done next cycle.
//     Count=65 -> Error 1 cycle, Busy stays 0.
//  5. Start pulsed again mid-RUN with new operands
//     -> ignored; original transfer completes unchanged.
//  6. nReset low during cycle 2 of a Count=8 copy
//     -> WriteEnable/Busy drop immediately; only 1 destination register written; idle after release.

Source files
------------

// File: rtl/regfile_block_mover.sv
// Block copy/fill initiator for a 64x16 register file.
// Port B reads the source, port A writes the destination, one register per cycle.
// Copies that overlap forward run descending so no source is overwritten before it is read.
module regfile_block_mover #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_fill,
  input  logic [AW-1:0] i_src_base,
  input  logic [AW-1:0] i_dst_base,
  input  logic [AW:0]   i_count,
  input  logic [DW-1:0] i_fill_data,
  input  logic [DW-1:0] i_read_data_b,
  output logic [AW-1:0] o_address_a,
  output logic [AW-1:0] o_address_b,
  output logic [DW-1:0] o_write_data,
  output logic          o_write_enable,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error
);

  localparam logic [AW:0] MaxCount = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        r_state;
  logic          r_fill;
  logic [DW-1:0] r_fill_data;
  logic [AW-1:0] r_src_ptr;
  logic [AW-1:0] r_dst_ptr;
  logic [AW:0]   r_remaining;
  logic          r_desc;
  logic          r_we;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic [AW-1:0] w_diff;
  logic [AW:0]   w_count_m1;
  logic [AW-1:0] w_src_last;
  logic [AW-1:0] w_dst_last;
  logic          w_overlap;
  logic          w_last;

  // Direction decision and end-of-block pointers, evaluated on the Start operands.
  assign w_diff     = i_dst_base - i_src_base;
  assign w_count_m1 = i_count - (AW+1)'(1);
  assign w_src_last = i_src_base + w_count_m1[AW-1:0];
  assign w_dst_last = i_dst_base + w_count_m1[AW-1:0];
  // Destination starts strictly inside the source block: ascending would clobber unread source.
  assign w_overlap  = !i_fill && (w_diff != '0) && ({1'b0, w_diff} <= w_count_m1);
  assign w_last     = (r_remaining == (AW+1)'(1));

  // Transfer FSM with registered strobes; pointers walk mod 2**AW.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_fill      <= 1'b0;
      r_fill_data <= '0;
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_desc      <= 1'b0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (i_count > MaxCount) begin
              r_error <= 1'b1;
            end else if (i_count == '0) begin
              r_state <= StDone;
              r_busy  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state     <= StRun;
              r_we        <= 1'b1;
              r_busy      <= 1'b1;
              r_fill      <= i_fill;
              r_fill_data <= i_fill_data;
              r_remaining <= i_count;
              r_desc      <= w_overlap;
              if (w_overlap) begin
                r_src_ptr <= w_src_last;
                r_dst_ptr <= w_dst_last;
              end else begin
                r_src_ptr <= i_src_base;
                r_dst_ptr <= i_dst_base;
              end
            end
          end
        end
        StRun: begin
          if (w_last) begin
            r_state <= StDone;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_remaining <= r_remaining - (AW+1)'(1);
            if (r_desc) begin
              r_src_ptr <= r_src_ptr - AW'(1);
              r_dst_ptr <= r_dst_ptr - AW'(1);
            end else begin
              r_src_ptr <= r_src_ptr + AW'(1);
              r_dst_ptr <= r_dst_ptr + AW'(1);
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Write data bypasses straight from port B so a copy moves one register per cycle.
  assign o_write_data   = r_fill ? r_fill_data : i_read_data_b;
  assign o_address_a    = r_dst_ptr;
  assign o_address_b    = r_src_ptr;
  assign o_write_enable = r_we;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;

endmodule

// File: tb/tb_regfile_block_mover.sv
// Scoreboard bench for regfile_block_mover with a behavioural 64x16 register file.
module tb_regfile_block_mover;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;
  localparam int KW = 1;  // write event
  localparam int KD = 2;  // done pulse
  localparam int KE = 3;  // error pulse

  typedef struct {
    int          kind;
    logic [5:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          fill = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [AW:0]   count = '0;
  logic [DW-1:0] fill_data = '0;
  logic [DW-1:0] rd_b;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata;
  logic          we;
  logic          busy;
  logic          done;
  logic          error;

  logic [DW-1:0] mem [64];
  logic          pk_en = 1'b0;
  logic [AW-1:0] pk_addr = '0;
  logic [DW-1:0] pk_data = '0;

  exp_t sb[$];
  int   cyc = 0;
  int   t0 = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  regfile_block_mover #(.AW(AW), .DW(DW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_fill         (fill),
    .i_src_base     (src_base),
    .i_dst_base     (dst_base),
    .i_count        (count),
    .i_fill_data    (fill_data),
    .i_read_data_b  (rd_b),
    .o_address_a    (addr_a),
    .o_address_b    (addr_b),
    .o_write_data   (wdata),
    .o_write_enable (we),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error)
  );

  always #5 clk = ~clk;

  assign rd_b = mem[addr_b];

  // Register file model plus bench preload port; cycle counter.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (we) mem[addr_a] <= wdata;
      if (pk_en) mem[pk_addr] <= pk_data;
    end
  end

  task automatic sb_check(input int k, input logic [5:0] a, input logic [15:0] d);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL unexpected_event kind=%0d addr=%0d data=%h cyc=%0d (nothing expected)",
               k, a, d, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.addr != a || e.data != d || e.cyc != cyc) begin
        n_miss++;
        $display("FAIL sb_event got kind=%0d addr=%0d data=%h cyc=%0d want kind=%0d addr=%0d data=%h cyc=%0d",
                 k, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (we) sb_check(KW, addr_a, wdata);
        if (done) sb_check(KD, 6'd0, 16'd0);
        if (error) sb_check(KE, 6'd0, 16'd0);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [15:0] d);
    @(negedge clk);
    pk_en = 1'b1;
    pk_addr = AW'(a);
    pk_data = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // off = 0 is the first cycle after the Start edge.
  task automatic push(input int k, input int a, input logic [15:0] d, input int off);
    exp_t e;
    e.kind = k;
    e.addr = 6'(a);
    e.data = d;
    e.cyc  = t0 + 1 + off;
    sb.push_back(e);
  endtask

  task automatic issue(input logic f, input int s, input int d, input int c,
                       input logic [15:0] fd);
    @(negedge clk);
    fill = f;
    src_base = AW'(s);
    dst_base = AW'(d);
    count = (AW+1)'(c);
    fill_data = fd;
    start = 1'b1;
    t0 = cyc;
  endtask

  task automatic drop_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(name, int'(busy), 0);
    chk({name, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_we", int'(we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_addr_a", int'(addr_a), 0);
    chk("rst_addr_b", int'(addr_b), 0);
    #20;
    rst_n = 1'b1;

    // 1: plain ascending copy
    poke(4, 16'h00A1);
    poke(5, 16'h00A2);
    poke(6, 16'h00A3);
    issue(1'b0, 4, 20, 3, 16'h0);
    push(KW, 20, 16'h00A1, 0);
    push(KW, 21, 16'h00A2, 1);
    push(KW, 22, 16'h00A3, 2);
    push(KD, 0, 16'h0, 3);
    drop_start();
    chk("t1_busy", int'(busy), 1);
    wait_idle("t1_idle");
    chk("t1_r20", int'(mem[20]), 16'h00A1);
    chk("t1_r22", int'(mem[22]), 16'h00A3);
    chk("t1_r23", int'(mem[23]), 16'h1017);

    // 2: forward overlap runs descending
    poke(10, 16'd1);
    poke(11, 16'd2);
    poke(12, 16'd3);
    poke(13, 16'd4);
    issue(1'b0, 10, 12, 4, 16'h0);
    push(KW, 15, 16'd4, 0);
    push(KW, 14, 16'd3, 1);
    push(KW, 13, 16'd2, 2);
    push(KW, 12, 16'd1, 3);
    push(KD, 0, 16'h0, 4);
    drop_start();
    wait_idle("t2_idle");
    chk("t2_r12", int'(mem[12]), 1);
    chk("t2_r15", int'(mem[15]), 4);

    // 3: fill wrapping past 63
    issue(1'b1, 5, 62, 4, 16'hBEEF);
    push(KW, 62, 16'hBEEF, 0);
    push(KW, 63, 16'hBEEF, 1);
    push(KW, 0, 16'hBEEF, 2);
    push(KW, 1, 16'hBEEF, 3);
    push(KD, 0, 16'h0, 4);
    drop_start();
    wait_idle("t3_idle");
    chk("t3_r0", int'(mem[0]), 16'hBEEF);
    chk("t3_r63", int'(mem[63]), 16'hBEEF);
    chk("t3_r2", int'(mem[2]), 16'h1002);

    // 4: zero count and oversize count
    issue(1'b0, 0, 30, 0, 16'h0);
    push(KD, 0, 16'h0, 0);
    drop_start();
    chk("t4_zero_busy", int'(busy), 1);
    wait_idle("t4_zero_idle");
    chk("t4_r30", int'(mem[30]), 16'h101E);
    issue(1'b0, 0, 30, 65, 16'h0);
    push(KE, 0, 16'h0, 0);
    drop_start();
    chk("t4_err_busy", int'(busy), 0);
    @(negedge clk);
    chk("t4_err_busy2", int'(busy), 0);
    chk("t4_sb", sb.size(), 0);

    // 5: Start during RUN is ignored
    issue(1'b0, 30, 40, 5, 16'h0);
    push(KW, 40, 16'h101E, 0);
    push(KW, 41, 16'h101F, 1);
    push(KW, 42, 16'h1020, 2);
    push(KW, 43, 16'h1021, 3);
    push(KW, 44, 16'h1022, 4);
    push(KD, 0, 16'h0, 5);
    drop_start();
    @(negedge clk);
    fill = 1'b1;
    dst_base = 6'd0;
    count = 7'd3;
    fill_data = 16'hDEAD;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("t5_idle");
    chk("t5_r44", int'(mem[44]), 16'h1022);
    chk("t5_r0", int'(mem[0]), 16'hBEEF);

    // 6: reset in the middle of a copy
    for (int i = 0; i < 8; i++) poke(48 + i, 16'h5500 + 16'(i));
    issue(1'b0, 48, 56, 8, 16'h0);
    push(KW, 56, 16'h5500, 0);
    drop_start();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_we_drop", int'(we), 0);
    chk("t6_busy_drop", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy_after", int'(busy), 0);
    chk("t6_addr_a", int'(addr_a), 0);
    chk("t6_sb", sb.size(), 0);
    chk("t6_r56", int'(mem[56]), 16'h5500);
    chk("t6_r57", int'(mem[57]), 16'h1039);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
